channel_event_fifo: RTL and testbench

//  Event-framed FIFO directly downstream of ChannelDigitalTop. Captures the 16-bit words the

---
 rtl/channel_event_fifo.sv | 149 ++++++++++++++
 tb/tb_channel_event_fifo.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_event_fifo.sv
// -----------------------------------------------------------------------------
// channel_event_fifo
//
// Event-framed word FIFO placed directly after the channel digital block.
// The channel writes 16-bit words while i_AdcStringWrite is high; one event is
// one contiguous run of strobed words, and it ends when the strobe falls.
// Each word is held for one cycle in a staging register. It is then written to
// RAM together with a "last" flag. The flag is simply "the strobe has dropped".
// The read side presents only complete events on a first-word-fall-through
// valid/ready stream.
//
// Ports
//   clk              system clock, rising edge
//   resetn           asynchronous active-low reset
//   i_AdcStringWrite channel write strobe, one word per high cycle
//   i_AdcString      channel word, sampled while the strobe is high
//   o_FifoHalfFull   registered: word count >= g_Depth/2
//   o_Valid          o_Data holds a word of a completely stored event
//   i_Ready          readout accepts o_Data this cycle when o_Valid is high
//   o_Data           head word
//   o_Last           head word is the final word of its event
//   o_EventCount     number of complete events held
//   o_Overflow       sticky, set when a word is dropped; cleared only by reset
// -----------------------------------------------------------------------------
module channel_event_fifo #(
  parameter int g_Depth     = 64,
  parameter int g_AddrWidth = 6
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   i_AdcStringWrite,
  input  logic [15:0]            i_AdcString,
  output logic                   o_FifoHalfFull,
  output logic                   o_Valid,
  input  logic                   i_Ready,
  output logic [15:0]            o_Data,
  output logic                   o_Last,
  output logic [g_AddrWidth:0]   o_EventCount,
  output logic                   o_Overflow
);

  localparam int CW = g_AddrWidth + 1;
  localparam logic [CW-1:0]          DEPTH    = CW'(g_Depth);
  localparam logic [CW-1:0]          DEPTH_M1 = CW'(g_Depth - 1);
  localparam logic [CW-1:0]          HALF     = CW'(g_Depth / 2);
  localparam logic [CW-1:0]          CNT_ONE  = CW'(1);
  localparam logic [g_AddrWidth-1:0] PTR_ONE  = g_AddrWidth'(1);

  // Each entry is {last, data}.
  logic [16:0]            ram [g_Depth];

  logic [g_AddrWidth-1:0] wr_ptr;
  logic [g_AddrWidth-1:0] rd_ptr;
  logic [CW-1:0]          word_cnt;
  logic [CW-1:0]          word_cnt_next;
  logic [CW-1:0]          event_cnt;
  logic [CW-1:0]          event_cnt_next;
  logic [CW-1:0]          room_cnt;
  logic                   stage_valid;
  logic [15:0]            stage_data;
  logic                   half_full;
  logic                   overflow;

  logic                   read_fire;
  logic                   commit_last;
  logic                   commit;
  logic                   head_last;

  // The head is always part of a complete event because events are stored in
  // order and the event counter only counts events whose closing word is in RAM.
  assign o_Valid      = (event_cnt != '0);
  assign head_last    = ram[rd_ptr][16];
  assign o_Data       = ram[rd_ptr][15:0];
  assign o_Last       = o_Valid & head_last;
  assign o_EventCount = event_cnt;
  assign o_FifoHalfFull = half_full;
  assign o_Overflow   = overflow;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    read_fire      = 1'b0;
    commit_last    = 1'b0;
    room_cnt       = word_cnt;
    commit         = 1'b0;
    word_cnt_next  = word_cnt;
    event_cnt_next = event_cnt;

    read_fire   = o_Valid & i_Ready;
    // The strobe has already fallen in the cycle after the final word, so the
    // staged word closes the event.
    commit_last = ~i_AdcStringWrite;
    // A read in this cycle frees its slot before the full check.
    room_cnt    = read_fire ? (word_cnt - CNT_ONE) : word_cnt;

    // Framing-safe full rule: one slot is always held back for a closing word.
    // An event that overflows therefore still ends with a last-flagged entry.
    if (stage_valid) begin
      if (commit_last) commit = (room_cnt < DEPTH);
      else             commit = (room_cnt < DEPTH_M1);
    end

    case ({commit, read_fire})
      2'b10:   word_cnt_next = word_cnt + CNT_ONE;
      2'b01:   word_cnt_next = word_cnt - CNT_ONE;
      default: word_cnt_next = word_cnt;
    endcase

    case ({commit & commit_last, read_fire & head_last})
      2'b10:   event_cnt_next = event_cnt + CNT_ONE;
      2'b01:   event_cnt_next = event_cnt - CNT_ONE;
      default: event_cnt_next = event_cnt;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      word_cnt    <= '0;
      event_cnt   <= '0;
      stage_valid <= 1'b0;
      stage_data  <= '0;
      half_full   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      stage_valid <= i_AdcStringWrite;
      if (i_AdcStringWrite) stage_data <= i_AdcString;

      if (commit)    wr_ptr <= wr_ptr + PTR_ONE;
      if (read_fire) rd_ptr <= rd_ptr + PTR_ONE;
      if (stage_valid && !commit) overflow <= 1'b1;

      word_cnt  <= word_cnt_next;
      event_cnt <= event_cnt_next;
      half_full <= (word_cnt_next >= HALF);
    end
  end

  // NOTE: the storage array has no reset. Entries are only visible between
  // rd_ptr and wr_ptr, and resetting the pointers makes stale contents
  // unreachable.
  always_ff @(posedge clk) begin
    if (commit) ram[wr_ptr] <= {commit_last, stage_data};
  end

endmodule

// File: tb/tb_channel_event_fifo.sv
// -----------------------------------------------------------------------------
// Testbench for channel_event_fifo.
// A queue-based reference model tracks the words stored, the complete events
// and the sticky overflow. Each word the model accepts is pushed onto a
// scoreboard queue. A monitor on the falling edge pops that queue on every
// observed transfer, and it compares the DUT status outputs with the model.
// -----------------------------------------------------------------------------
module tb_channel_event_fifo;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk;
  logic          resetn;
  logic          i_AdcStringWrite;
  logic [15:0]   i_AdcString;
  logic          o_FifoHalfFull;
  logic          o_Valid;
  logic          i_Ready;
  logic [15:0]   o_Data;
  logic          o_Last;
  logic [AW:0]   o_EventCount;
  logic          o_Overflow;

  channel_event_fifo #(.g_Depth(DEPTH), .g_AddrWidth(AW)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .i_AdcStringWrite (i_AdcStringWrite),
    .i_AdcString      (i_AdcString),
    .o_FifoHalfFull   (o_FifoHalfFull),
    .o_Valid          (o_Valid),
    .i_Ready          (i_Ready),
    .o_Data           (o_Data),
    .o_Last           (o_Last),
    .o_EventCount     (o_EventCount),
    .o_Overflow       (o_Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [16:0] m_store [$];   // words held, {last, data}
  logic [16:0] sb_q    [$];   // expected output stream
  int          m_events;
  bit          m_ovf;
  bit          m_stage_valid;
  logic [15:0] m_stage_word;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_store.delete();
      sb_q.delete();
      m_events      = 0;
      m_ovf         = 1'b0;
      m_stage_valid = 1'b0;
    end else begin
      logic [16:0] w;
      bit          last;
      if (i_Ready && m_events > 0) begin
        w = m_store.pop_front();
        if (w[16]) m_events--;
      end
      if (m_stage_valid) begin
        last = !i_AdcStringWrite;
        if (m_store.size() < (last ? DEPTH : DEPTH - 1)) begin
          m_store.push_back({last, m_stage_word});
          sb_q.push_back({last, m_stage_word});
          if (last) m_events++;
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_stage_valid = i_AdcStringWrite;
      m_stage_word  = i_AdcString;
    end
  end

  // ---------------- monitor ----------------
  int          n_xfer    = 0;
  int          n_last    = 0;
  logic [15:0] last_data = '0;

  always @(negedge clk) begin
    if (resetn) begin
      logic [16:0] e;
      check("valid",       o_Valid, (m_events != 0));
      check("event_count", o_EventCount, m_events);
      check("half_full",   o_FifoHalfFull, (m_store.size() >= DEPTH / 2));
      check("overflow",    o_Overflow, m_ovf);
      if (o_Valid && i_Ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL transfer: got word 0x%0h expected no transfer at %0t", o_Data, $time);
        end else begin
          e = sb_q.pop_front();
          check("data", o_Data, e[15:0]);
          check("last", o_Last, e[16]);
        end
        n_xfer++;
        if (o_Last) begin
          n_last++;
          last_data = o_Data;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic w, input logic [15:0] d, input logic r);
    i_AdcStringWrite = w;
    i_AdcString      = d;
    i_Ready          = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    i_AdcStringWrite = 1'b0;
    i_Ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic drain();
    int k = 0;
    while ((o_Valid || sb_q.size() != 0) && k < 400) begin
      step(1'b0, 16'h0, 1'b1);
      k++;
    end
    step(1'b0, 16'h0, 1'b0);
    check("drain_valid", o_Valid, 1'b0);
    check("drain_events", o_EventCount, 0);
  endtask

  initial begin
    int x0;
    resetn = 1'b0;
    i_AdcStringWrite = 1'b0;
    i_AdcString = '0;
    i_Ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", o_Valid, 1'b0);
    check("rst_last", o_Last, 1'b0);
    check("rst_half", o_FifoHalfFull, 1'b0);
    check("rst_events", o_EventCount, 0);
    check("rst_ovf", o_Overflow, 1'b0);
    resetn = 1'b1;

    // 1: single 16-word event, reader always ready
    for (int i = 0; i < 16; i++) step(1'b1, (i == 0) ? 16'h000F : 16'hA000 + 16'(i), 1'b1);
    check("t1_not_yet_valid", o_Valid, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    check("t1_valid_rise", o_Valid, 1'b1);
    check("t1_one_event", o_EventCount, 1);
    x0 = n_xfer;
    drain();
    check("t1_words", n_xfer - x0, 16);
    check("t1_last_data", last_data, 16'hA00F);

    // 2: pile-up, 31-word event
    x0 = n_last;
    for (int i = 0; i < 31; i++) step(1'b1, 16'hB000 + 16'(i), 1'b1);
    step(1'b0, 16'h0, 1'b1);
    drain();
    check("t2_single_last", n_last - x0, 1);
    check("t2_last_data", last_data, 16'hB01E);

    // 3: half-full threshold
    for (int i = 0; i < 16; i++) step(1'b1, 16'hC000 + 16'(i), 1'b0);
    step(1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 16'hC100 + 16'(i), 1'b0);
    check("t3_half_before", o_FifoHalfFull, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    check("t3_half_set", o_FifoHalfFull, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    check("t3_half_clear", o_FifoHalfFull, 1'b0);
    drain();

    // 4: overflow inside one 70-word event
    do_reset();
    for (int i = 0; i < 70; i++) step(1'b1, 16'h4000 + 16'(i), 1'b0);
    step(1'b0, 16'h0, 1'b0);
    check("t4_overflow", o_Overflow, 1'b1);
    check("t4_one_event", o_EventCount, 1);
    x0 = n_xfer;
    drain();
    check("t4_words", n_xfer - x0, 64);
    check("t4_last_data", last_data, 16'h4045);

    // 5: back-to-back events with one idle cycle, concurrent reads
    do_reset();
    x0 = n_last;
    for (int i = 0; i < 5; i++) step(1'b1, 16'h5000 + 16'(i), 1'b1);
    step(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 16'h5100 + 16'(i), 1'b1);
    step(1'b0, 16'h0, 1'b1);
    drain();
    check("t5_two_lasts", n_last - x0, 2);

    // 6: asynchronous reset mid-event and mid-readout
    for (int i = 0; i < 8; i++) step(1'b1, 16'h6000 + 16'(i), 1'b0);
    step(1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 16'h6100 + 16'(i), 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_valid", o_Valid, 1'b0);
    check("t6_last", o_Last, 1'b0);
    check("t6_half", o_FifoHalfFull, 1'b0);
    check("t6_events", o_EventCount, 0);
    check("t6_ovf", o_Overflow, 1'b0);
    i_AdcStringWrite = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    x0 = n_xfer;
    for (int i = 0; i < 6; i++) step(1'b1, 16'h6200 + 16'(i), 1'b0);
    step(1'b0, 16'h0, 1'b0);
    check("t6_clean_event", o_EventCount, 1);
    drain();
    check("t6_words", n_xfer - x0, 6);
    check("t6_last_data", last_data, 16'h6205);

    // random events, gaps and reader back-pressure
    for (int ev = 0; ev < 60; ev++) begin
      int len = $urandom_range(1, 40);
      int gap = $urandom_range(1, 3);
      int rdy_pct = (ev % 10 < 3) ? 5 : 70;
      for (int i = 0; i < len; i++)
        step(1'b1, 16'($urandom), ($urandom_range(0, 99) < rdy_pct));
      for (int g = 0; g < gap; g++)
        step(1'b0, 16'h0, ($urandom_range(0, 99) < rdy_pct));
    end
    drain();
    check("rand_sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
